mem_port_bank: RTL and testbench

//  Synthesizable multi-port word memory. It serves the simple ren/raddr/rdata and wen/waddr/wdata/wstrb

---
 rtl/mem_port_bank.sv | 167 ++++++++++++++++
 tb/tb_mem_port_bank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_bank.sv
// mem_port_bank -- multi-port, byte-strobed word memory with a configurable read latency.
//
// Each of the NP ports has an independent read channel and an independent write channel.
//
// Ports:
//   clk      posedge clock for all logic
//   rst      synchronous active-high reset. It clears the read pipe, rdata and oob_err.
//            It does not clear the storage.
//   ren      [NP]              per-port read request
//   raddr    [NP*AW]           per-port read word address, port p at [p*AW +: AW]
//   rdata    [NP*AXI_WIDTH]    per-port read data; holds its last value while rvalid=0
//   rvalid   [NP]              per-port one-cycle pulse, RD_LAT cycles after ren
//   wen      [NP]              per-port write request
//   waddr    [NP*AW]           per-port write word address
//   wdata    [NP*AXI_WIDTH]    per-port write data
//   wstrb    [NP*AXI_WIDTH/8]  per-port byte enables
//   oob_err  sticky flag: some enabled access used an address >= DEPTH
//
// Handshake: requests have no ready signal and are always accepted. A request is taken
// on every posedge where ren/wen is high and rst is low. A read result is presented for
// exactly one cycle, with rvalid high. The consumer cannot apply backpressure.
module mem_port_bank #(
    parameter int AXI_WIDTH   = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int LSB         = $clog2(AXI_WIDTH) - 3,
    parameter int AW          = ADDR_WIDTH - LSB,
    parameter int DEPTH       = 1024,
    parameter int NP          = 2,
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NP-1:0]             ren,
    input  logic [NP*AW-1:0]          raddr,
    output logic [NP*AXI_WIDTH-1:0]   rdata,
    output logic [NP-1:0]             rvalid,
    input  logic [NP-1:0]             wen,
    input  logic [NP*AW-1:0]          waddr,
    input  logic [NP*AXI_WIDTH-1:0]   wdata,
    input  logic [NP*AXI_WIDTH/8-1:0] wstrb,
    output logic                      oob_err
);

    localparam int NB = AXI_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AXI_WIDTH-1:0] mem [DEPTH];

    // Per-port address views and range flags.
    logic [AW-1:0] ra [NP];
    logic [AW-1:0] wa [NP];
    logic [IW-1:0] ri [NP];
    logic [IW-1:0] wi [NP];
    logic [NP-1:0] ra_ok;
    logic [NP-1:0] wa_ok;

    for (genvar p = 0; p < NP; p++) begin : g_addr
        assign ra[p]    = raddr[p*AW +: AW];
        assign wa[p]    = waddr[p*AW +: AW];
        // The compare is done in 64 bits, so it is an unsigned compare against DEPTH.
        // The address does not wrap.
        assign ra_ok[p] = (64'(ra[p]) < 64'(DEPTH));
        assign wa_ok[p] = (64'(wa[p]) < 64'(DEPTH));
        // The storage index is only used when the matching *_ok flag is set.
        assign ri[p]    = ra[p][IW-1:0];
        assign wi[p]    = wa[p][IW-1:0];
    end

    // Storage write.
    // Ports are visited in ascending order. For one byte of one word, the highest-index
    // port with its strobe set is assigned last, so it wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (wen[p] && wa_ok[p]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wstrb[p*NB + b]) begin
                            mem[wi[p]][b*8 +: 8] <= wdata[p*AXI_WIDTH + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Word captured for each read in the request cycle.
    // An out-of-range read returns zero.
    // In write-first mode, bytes written this cycle are merged over the old contents.
    // The merge uses the same port-priority rule as the storage write.
    logic [AXI_WIDTH-1:0] rd_word [NP];

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rd_word[p] = '0;
            if (ra_ok[p]) begin
                rd_word[p] = mem[ri[p]];
                if (WRITE_FIRST != 0) begin
                    for (int q = 0; q < NP; q++) begin
                        if (wen[q] && wa_ok[q] && (wa[q] == ra[p])) begin
                            for (int b = 0; b < NB; b++) begin
                                if (wstrb[q*NB + b]) begin
                                    rd_word[p][b*8 +: 8] = wdata[q*AXI_WIDTH + b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Read pipe with RD_LAT stages.
    // Stage 0 is loaded at the request edge. The last stage drives the outputs.
    // A stage's data register only loads when the stage before it holds a valid entry.
    // As a result, the last stage keeps the most recent result while no read is completing.
    logic [NP-1:0]        v_pipe [RD_LAT];
    logic [AXI_WIDTH-1:0] d_pipe [RD_LAT][NP];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                v_pipe[k] <= '0;
                for (int p = 0; p < NP; p++) begin
                    d_pipe[k][p] <= '0;
                end
            end
        end else begin
            v_pipe[0] <= ren;
            for (int p = 0; p < NP; p++) begin
                if (ren[p]) begin
                    d_pipe[0][p] <= rd_word[p];
                end
            end
            for (int k = 1; k < RD_LAT; k++) begin
                v_pipe[k] <= v_pipe[k-1];
                for (int p = 0; p < NP; p++) begin
                    if (v_pipe[k-1][p]) begin
                        d_pipe[k][p] <= d_pipe[k-1][p];
                    end
                end
            end
        end
    end

    always_comb begin
        rvalid = v_pipe[RD_LAT-1];
        rdata  = '0;
        for (int p = 0; p < NP; p++) begin
            rdata[p*AXI_WIDTH +: AXI_WIDTH] = d_pipe[RD_LAT-1][p];
        end
    end

    // Sticky out-of-range flag. It is set by any enabled access, read or write.
    // A write sets it even when its strobes are all zero.
    logic [NP-1:0] acc_oob;
    assign acc_oob = (ren & ~ra_ok) | (wen & ~wa_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else if (|acc_oob) begin
            oob_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_bank.sv
module tb_mem_port_bank;

    localparam int W     = 128;
    localparam int AW    = 28;
    localparam int NP    = 2;
    localparam int DEPTH = 1024;
    localparam int NB    = W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     ren;
    logic [NP*AW-1:0]  raddr;
    logic [NP-1:0]     wen;
    logic [NP*AW-1:0]  waddr;
    logic [NP*W-1:0]   wdata;
    logic [NP*NB-1:0]  wstrb;

    // Three instances share the stimulus:
    //   a: RD_LAT=2, write-first
    //   b: RD_LAT=1, write-first
    //   c: RD_LAT=3, read-first
    logic [NP*W-1:0] rdata_a, rdata_b, rdata_c;
    logic [NP-1:0]   rvalid_a, rvalid_b, rvalid_c;
    logic            oob_a, oob_b, oob_c;

    mem_port_bank #(.RD_LAT(2), .WRITE_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .oob_err(oob_a));
    mem_port_bank #(.RD_LAT(1), .WRITE_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .oob_err(oob_b));
    mem_port_bank #(.RD_LAT(3), .WRITE_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .oob_err(oob_c));

    // clock
    always #5 clk = ~clk;

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;

    int lat [3] = '{2, 1, 3};
    int wfm [3] = '{1, 1, 0};

    logic [W-1:0]  m_mem [DEPTH];
    logic [NP-1:0] m_v [3][3];
    logic [W-1:0]  m_d [3][NP][3];
    logic [W-1:0]  m_r [3][NP];
    logic          m_oob [3];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {NB{b}};
    endfunction

    task automatic idle();
        ren   = '0;
        wen   = '0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_oob[i] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_v[i][k] = '0;
            end
            for (int p = 0; p < NP; p++) begin
                m_r[i][p] = '0;
                for (int k = 0; k < 3; k++) begin
                    m_d[i][p][k] = '0;
                end
            end
        end
    endtask

    // Advance one clock edge and update the reference model from the inputs sampled at
    // that edge. Then compare every instance's outputs, 1 time unit after the edge.
    task automatic tick();
        logic [W-1:0]  old_w, new_w;
        logic [AW-1:0] ra, wa;
        logic [NP-1:0] ov;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 2; k >= 1; k--) begin
                    m_v[i][k] = m_v[i][k-1];
                    for (int p = 0; p < NP; p++) begin
                        m_d[i][p][k] = m_d[i][p][k-1];
                    end
                end
                m_v[i][0] = ren;
            end
            for (int p = 0; p < NP; p++) begin
                ra    = raddr[p*AW +: AW];
                old_w = '0;
                new_w = '0;
                if (ra < AW'(DEPTH)) begin
                    old_w = m_mem[ra[9:0]];
                    new_w = old_w;
                    for (int q = 0; q < NP; q++) begin
                        wa = waddr[q*AW +: AW];
                        if (wen[q] && wa == ra) begin
                            for (int b = 0; b < NB; b++) begin
                                if (wstrb[q*NB + b]) begin
                                    new_w[b*8 +: 8] = wdata[q*W + b*8 +: 8];
                                end
                            end
                        end
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    m_d[i][p][0] = (wfm[i] != 0) ? new_w : old_w;
                end
                if ((ren[p] && ra >= AW'(DEPTH)) || (wen[p] && waddr[p*AW +: AW] >= AW'(DEPTH))) begin
                    for (int i = 0; i < 3; i++) begin
                        m_oob[i] = 1'b1;
                    end
                end
            end
            for (int q = 0; q < NP; q++) begin
                wa = waddr[q*AW +: AW];
                if (wen[q] && wa < AW'(DEPTH)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wstrb[q*NB + b]) begin
                            m_mem[wa[9:0]][b*8 +: 8] = wdata[q*W + b*8 +: 8];
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < NP; p++) begin
                    if (m_v[i][lat[i]-1][p]) begin
                        m_r[i][p] = m_d[i][p][lat[i]-1];
                    end
                end
            end
        end
        #1;
        check("rvalid_a", W'(rvalid_a), W'(m_v[0][lat[0]-1]));
        check("rvalid_b", W'(rvalid_b), W'(m_v[1][lat[1]-1]));
        check("rvalid_c", W'(rvalid_c), W'(m_v[2][lat[2]-1]));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rdata_a[%0d]", p), rdata_a[p*W +: W], m_r[0][p]);
            check($sformatf("rdata_b[%0d]", p), rdata_b[p*W +: W], m_r[1][p]);
            check($sformatf("rdata_c[%0d]", p), rdata_c[p*W +: W], m_r[2][p]);
        end
        check("oob_a", W'(oob_a), W'(m_oob[0]));
        check("oob_b", W'(oob_b), W'(m_oob[1]));
        check("oob_c", W'(oob_c), W'(m_oob[2]));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) begin
            return AW'(1020 + $urandom_range(0, 8));
        end
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [W-1:0] d0;
        d0 = 128'h0123456789ABCDEF0123456789ABCDEF;
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
        end
        model_reset();

        // reset
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("reset_rvalid", W'(rvalid_a), '0);
        check("reset_rdata", rdata_a[W-1:0], '0);
        check("reset_oob", W'(oob_a), '0);
        rst = 1'b0;

        // Storage is not cleared by reset, so give every word a known value first.
        for (int a = 0; a < DEPTH / 2; a++) begin
            wen   = 2'b11;
            waddr = {AW'(2*a + 1), AW'(2*a)};
            wstrb = '1;
            wdata = '0;
            tick();
        end
        idle();

        // 1: read latency 2 on instance a
        wen   = 2'b01;
        waddr = {AW'(0), AW'(5)};
        wdata = {W'(0), d0};
        wstrb = '1;
        tick();
        idle();
        ren   = 2'b01;
        raddr = {AW'(0), AW'(5)};
        tick();
        idle();
        check("t1_rvalid_early", W'(rvalid_a[0]), W'(1'b0));
        tick();
        check("t1_rvalid", W'(rvalid_a[0]), W'(1'b1));
        check("t1_rdata", rdata_a[W-1:0], d0);

        // 2: partial strobe over a preloaded word
        wen   = 2'b01;
        waddr = {AW'(0), AW'(7)};
        wdata = {W'(0), rep(8'hAA)};
        wstrb = '1;
        tick();
        wdata = {W'(0), rep(8'h11)};
        wstrb = {16'h0000, 16'h000F};
        tick();
        idle();
        ren   = 2'b01;
        raddr = {AW'(0), AW'(7)};
        tick();
        idle();
        tick();
        check("t2_strobe", rdata_a[W-1:0], 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_11111111);

        // 3: read-during-write across ports
        wen   = 2'b01;
        waddr = {AW'(0), AW'(9)};
        wdata = {W'(0), rep(8'hFF)};
        wstrb = {16'h0000, 16'hFFFF};
        ren   = 2'b10;
        raddr = {AW'(9), AW'(0)};
        tick();
        idle();
        tick();
        check("t3_wf_rvalid", W'(rvalid_a[1]), W'(1'b1));
        check("t3_write_first", rdata_a[2*W-1:W], rep(8'hFF));
        tick();
        check("t3_rf_rvalid", W'(rvalid_c[1]), W'(1'b1));
        check("t3_read_first", rdata_c[2*W-1:W], '0);

        // 4: same-word write collision
        wen   = 2'b01;
        waddr = {AW'(0), AW'(3)};
        wdata = {W'(0), rep(8'h55)};
        wstrb = '1;
        tick();
        wen   = 2'b11;
        waddr = {AW'(3), AW'(3)};
        wdata = {rep(8'h33), rep(8'h22)};
        wstrb = {16'h0FF0, 16'h00FF};
        tick();
        idle();
        ren   = 2'b01;
        raddr = {AW'(0), AW'(3)};
        tick();
        idle();
        tick();
        check("t4_collision", rdata_a[W-1:0], 128'h55555555_33333333_33333333_22222222);

        // 5: out-of-range read and write, then reset during a pending read
        ren   = 2'b10;
        raddr = {AW'(1024), AW'(0)};
        tick();
        idle();
        check("t5_oob_set", W'(oob_a), W'(1'b1));
        tick();
        check("t5_oob_rvalid", W'(rvalid_a[1]), W'(1'b1));
        check("t5_oob_rdata", rdata_a[2*W-1:W], '0);
        wen   = 2'b01;
        waddr = {AW'(0), AW'(1024)};
        wdata = {W'(0), rep(8'hEE)};
        wstrb = '1;
        tick();
        idle();
        ren   = 2'b01;
        raddr = {AW'(0), AW'(0)};
        tick();
        idle();
        tick();
        check("t5_oob_wr_dropped", rdata_a[W-1:0], '0);
        check("t5_oob_sticky", W'(oob_a), W'(1'b1));
        ren   = 2'b01;
        raddr = {AW'(0), AW'(5)};
        tick();
        idle();
        rst = 1'b1;
        tick();
        check("t5_rst_rvalid", W'(rvalid_a), '0);
        check("t5_rst_rdata", rdata_a[W-1:0], '0);
        check("t5_rst_oob", W'(oob_a), '0);
        rst = 1'b0;
        tick();
        check("t5_no_late_rvalid", W'(rvalid_a), '0);

        // 6: random traffic against the reference model
        for (int c = 0; c < 10000; c++) begin
            rst   = ($urandom_range(0, 399) == 0);
            ren   = NP'($urandom_range(0, 3));
            wen   = NP'($urandom_range(0, 3));
            raddr = {rand_addr(), rand_addr()};
            waddr = {rand_addr(), rand_addr()};
            wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            wstrb = ($urandom_range(0, 7) == 0) ? '0 : {16'($urandom), 16'($urandom)};
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
